// File: rtl/scr1_pipe_mprf_wb_pkg.sv
`default_nettype none
// ============================================================================
// Module      : scr1_pipe_mprf_wb_pkg
// Description : Shared constants and types for the MPRF writeback /
//               operand-hazard unit.
// Revision    : 1.0 - initial release
// ============================================================================
package scr1_pipe_mprf_wb_pkg;

  // Architectural data width and register address width (use 4 for RVE)
  localparam int SCR1_XLEN      = 32;
  localparam int SCR1_AW        = 5;

  // Default number of loads that may be in flight at once
  localparam int SCR1_LDQ_DEPTH = 2;

  // Load-result hold register occupancy
  typedef enum logic {
    HOLD_EMPTY = 1'b0,
    HOLD_FULL  = 1'b1
  } scr1_hold_state_e;

endpackage : scr1_pipe_mprf_wb_pkg
`default_nettype wire

// File: rtl/scr1_pipe_mprf_wb_ldq.sv
`default_nettype none
// ============================================================================
// Module      : scr1_pipe_mprf_wb_ldq
// Description : In-order FIFO of outstanding load destination registers.
//               Loads retire in issue order, so the head entry always names
//               the destination of the next load response.
// Revision    : 1.0 - initial release
// ============================================================================
module scr1_pipe_mprf_wb_ldq
  import scr1_pipe_mprf_wb_pkg::*;
#(
  parameter int DW    = SCR1_AW,
  parameter int DEPTH = SCR1_LDQ_DEPTH
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push_i,
  input  logic [DW-1:0] data_i,
  input  logic          pop_i,
  output logic          full_o,
  output logic          empty_o,
  output logic [DW-1:0] head_o
);

  // Pointers carry one extra wrap bit so full and empty are distinguishable
  localparam int            PW      = $clog2(DEPTH);
  localparam logic [PW:0]   PTR_ONE = {{PW{1'b0}}, 1'b1};

  logic [PW:0]   wr_ptr_q;
  logic [PW:0]   rd_ptr_q;
  logic [DW-1:0] mem_q [DEPTH];

  logic          w_push;
  logic          w_pop;

  // Push into a full queue or pop from an empty one is ignored
  assign w_push = push_i & ~full_o;
  assign w_pop  = pop_i  & ~empty_o;

  // Pointer advance and storage write
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (w_push) begin
        mem_q[wr_ptr_q[PW-1:0]] <= data_i;
        wr_ptr_q                <= wr_ptr_q + PTR_ONE;
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + PTR_ONE;
      end
    end
  end

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PW] != rd_ptr_q[PW]) &&
                   (wr_ptr_q[PW-1:0] == rd_ptr_q[PW-1:0]);
  assign head_o  = mem_q[rd_ptr_q[PW-1:0]];

endmodule : scr1_pipe_mprf_wb_ldq
`default_nettype wire

// File: rtl/scr1_pipe_mprf_wb.sv
`default_nettype none
// ============================================================================
// Module      : scr1_pipe_mprf_wb
// Description : EXU-side writeback and operand-hazard unit for the MPRF.
//               Merges single-cycle ALU results and in-order load responses
//               onto the single MPRF write port, keeps a pending scoreboard
//               for outstanding load destinations, stalls decode on RAW/WAW
//               hazards and forwards same-cycle write data to the operands.
// Revision    : 1.0 - initial release
// ============================================================================
module scr1_pipe_mprf_wb
  import scr1_pipe_mprf_wb_pkg::*;
#(
  parameter int XLEN      = SCR1_XLEN,
  parameter int AW        = SCR1_AW,
  parameter int LDQ_DEPTH = SCR1_LDQ_DEPTH
) (
  input  logic            clk,
  input  logic            rst_n,

  // Decode-stage operand / destination addresses and hazard stall
  input  logic [AW-1:0]   dec_rs1_addr_i,
  input  logic [AW-1:0]   dec_rs2_addr_i,
  input  logic [AW-1:0]   dec_rd_addr_i,
  output logic            dec_stall_o,

  // Operands after bypass
  output logic [XLEN-1:0] exu_rs1_data_o,
  output logic [XLEN-1:0] exu_rs2_data_o,

  // Single-cycle ALU result (always accepted)
  input  logic            alu_wb_vd_i,
  input  logic [AW-1:0]   alu_wb_rd_i,
  input  logic [XLEN-1:0] alu_wb_data_i,

  // Load issue handshake
  input  logic            lsu_issue_vd_i,
  input  logic [AW-1:0]   lsu_issue_rd_i,
  output logic            lsu_issue_rdy_o,

  // Load response handshake
  input  logic            lsu_rsp_vd_i,
  input  logic [XLEN-1:0] lsu_rsp_data_i,
  input  logic            lsu_rsp_err_i,
  output logic            lsu_rsp_rdy_o,

  // MPRF read ports
  output logic [AW-1:0]   exu2mprf_rs1_addr_o,
  output logic [AW-1:0]   exu2mprf_rs2_addr_o,
  input  logic [XLEN-1:0] mprf2exu_rs1_data_i,
  input  logic [XLEN-1:0] mprf2exu_rs2_data_i,

  // MPRF write port
  output logic            exu2mprf_w_req_o,
  output logic [AW-1:0]   exu2mprf_rd_addr_o,
  output logic [XLEN-1:0] exu2mprf_rd_data_o
);

  localparam int NREG = 1 << AW;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [NREG-1:0]  pending_q;
  logic [NREG-1:0]  pending_d;

  scr1_hold_state_e hold_q;
  scr1_hold_state_e hold_d;
  logic [AW-1:0]    hold_rd_q;
  logic [AW-1:0]    hold_rd_d;
  logic [XLEN-1:0]  hold_data_q;
  logic [XLEN-1:0]  hold_data_d;

  // --------------------------------------------------------------------------
  // Combinational nets
  // --------------------------------------------------------------------------
  logic             w_ldq_full;
  logic             w_ldq_empty;
  logic [AW-1:0]    w_head_rd;

  logic             w_issue_acc;
  logic             w_rsp_acc;
  logic             w_rsp_wr;
  logic             w_alu_wr;

  logic [NREG-1:0]  w_set_mask;
  logic [NREG-1:0]  w_clr_mask;
  logic [NREG-1:0]  w_pend_eff;

  logic             w_req;
  logic [AW-1:0]    w_wr_addr;
  logic [XLEN-1:0]  w_wr_data;

  // --------------------------------------------------------------------------
  // Outstanding-load destination queue
  // --------------------------------------------------------------------------
  scr1_pipe_mprf_wb_ldq #(
    .DW    (AW),
    .DEPTH (LDQ_DEPTH)
  ) u_ldq (
    .clk     (clk),
    .rst_n   (rst_n),
    .push_i  (w_issue_acc),
    .data_i  (lsu_issue_rd_i),
    .pop_i   (w_rsp_acc),
    .full_o  (w_ldq_full),
    .empty_o (w_ldq_empty),
    .head_o  (w_head_rd)
  );

  // Issue readiness ignores a same-cycle pop: the freed slot appears next edge
  assign lsu_issue_rdy_o = ~w_ldq_full;
  assign w_issue_acc     = lsu_issue_vd_i & lsu_issue_rdy_o;

  // A response is only taken when the hold register can absorb a port conflict
  assign lsu_rsp_rdy_o   = (hold_q == HOLD_EMPTY) & ~w_ldq_empty;
  assign w_rsp_acc       = lsu_rsp_vd_i & lsu_rsp_rdy_o;

  // Accepted load response that actually produces a register write
  assign w_rsp_wr        = w_rsp_acc & ~lsu_rsp_err_i & (w_head_rd != '0);

  // An ALU result to x0 does not take the write port
  assign w_alu_wr        = alu_wb_vd_i & (alu_wb_rd_i != '0);

  // Write-port arbitration (ALU > hold > direct load) and pending-clear mask
  always_comb begin
    w_req       = 1'b0;
    w_wr_addr   = '0;
    w_wr_data   = '0;
    hold_d      = hold_q;
    hold_rd_d   = hold_rd_q;
    hold_data_d = hold_data_q;
    w_clr_mask  = '0;

    if (w_alu_wr) begin
      w_req     = 1'b1;
      w_wr_addr = alu_wb_rd_i;
      w_wr_data = alu_wb_data_i;
      // Losing load result parks in the hold register; stays pending
      if (w_rsp_wr) begin
        hold_d      = HOLD_FULL;
        hold_rd_d   = w_head_rd;
        hold_data_d = lsu_rsp_data_i;
      end
    end else if (hold_q == HOLD_FULL) begin
      w_req                 = 1'b1;
      w_wr_addr             = hold_rd_q;
      w_wr_data             = hold_data_q;
      hold_d                = HOLD_EMPTY;
      w_clr_mask[hold_rd_q] = 1'b1;
    end else if (w_rsp_wr) begin
      w_req                 = 1'b1;
      w_wr_addr             = w_head_rd;
      w_wr_data             = lsu_rsp_data_i;
      w_clr_mask[w_head_rd] = 1'b1;
    end

    // Faulted loads and loads to x0 retire without writing
    if (w_rsp_acc && !w_rsp_wr) begin
      w_clr_mask[w_head_rd] = 1'b1;
    end
  end

  // Pending bits raised by an accepted load issue
  always_comb begin
    w_set_mask = '0;
    if (w_issue_acc && (lsu_issue_rd_i != '0)) begin
      w_set_mask[lsu_issue_rd_i] = 1'b1;
    end
  end

  // Next scoreboard value; x0 is never pending
  always_comb begin
    pending_d    = (pending_q & ~w_clr_mask) | w_set_mask;
    pending_d[0] = 1'b0;
  end

  // Scoreboard and hold register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q   <= '0;
      hold_q      <= HOLD_EMPTY;
      hold_rd_q   <= '0;
      hold_data_q <= '0;
    end else begin
      pending_q   <= pending_d;
      hold_q      <= hold_d;
      hold_rd_q   <= hold_rd_d;
      hold_data_q <= hold_data_d;
    end
  end

  // --------------------------------------------------------------------------
  // Hazard detection: a register being written this cycle is no longer a
  // hazard, because the reader picks the value up from the bypass
  // --------------------------------------------------------------------------
  assign w_pend_eff  = pending_q & ~w_clr_mask;

  assign dec_stall_o = ((dec_rs1_addr_i != '0) & w_pend_eff[dec_rs1_addr_i]) |
                       ((dec_rs2_addr_i != '0) & w_pend_eff[dec_rs2_addr_i]) |
                       ((dec_rd_addr_i  != '0) & w_pend_eff[dec_rd_addr_i]);

  // --------------------------------------------------------------------------
  // MPRF ports and operand bypass
  // --------------------------------------------------------------------------
  assign exu2mprf_rs1_addr_o = dec_rs1_addr_i;
  assign exu2mprf_rs2_addr_o = dec_rs2_addr_i;

  assign exu2mprf_w_req_o    = w_req;
  assign exu2mprf_rd_addr_o  = w_wr_addr;
  assign exu2mprf_rd_data_o  = w_wr_data;

  assign exu_rs1_data_o = (w_req && (dec_rs1_addr_i != '0) && (w_wr_addr == dec_rs1_addr_i))
                          ? w_wr_data : mprf2exu_rs1_data_i;
  assign exu_rs2_data_o = (w_req && (dec_rs2_addr_i != '0) && (w_wr_addr == dec_rs2_addr_i))
                          ? w_wr_data : mprf2exu_rs2_data_i;

  // --------------------------------------------------------------------------
  // Protocol checks
  // --------------------------------------------------------------------------
`ifndef SYNTHESIS
  // ALU must not target a register that still awaits a load
  a_alu_rd_not_pending : assert property (
    @(posedge clk) disable iff (!rst_n)
    (alu_wb_vd_i && (alu_wb_rd_i != '0)) |-> !pending_q[alu_wb_rd_i]
  );

  // Every load response must pair with an outstanding load
  a_rsp_has_load : assert property (
    @(posedge clk) disable iff (!rst_n)
    lsu_rsp_vd_i |-> !w_ldq_empty
  );

  // A load must not be issued to a register that is already pending
  a_issue_rd_not_pending : assert property (
    @(posedge clk) disable iff (!rst_n)
    (w_issue_acc && (lsu_issue_rd_i != '0)) |-> !pending_q[lsu_issue_rd_i]
  );
`endif

endmodule : scr1_pipe_mprf_wb
`default_nettype wire

// File: tb/tb_scr1_pipe_mprf_wb.sv
`default_nettype none
// ============================================================================
// Module      : tb_scr1_pipe_mprf_wb
// Description : Directed self-checking bench for scr1_pipe_mprf_wb. Expected
//               MPRF writes are queued as stimulus is applied and popped as
//               the write port fires; a small register-file model answers
//               the read ports.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_scr1_pipe_mprf_wb;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd;
  logic        dec_stall;
  logic [31:0] exu_rs1, exu_rs2;
  logic        alu_vd;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        iss_vd;
  logic [4:0]  iss_rd;
  logic        iss_rdy;
  logic        rsp_vd;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        rsp_rdy;
  logic [4:0]  rd_a1, rd_a2;
  logic [31:0] rf_d1, rf_d2;
  logic        w_req;
  logic [4:0]  w_addr;
  logic [31:0] w_data;

  typedef struct packed {
    logic [4:0]  rd;
    logic [31:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  total = 0;
  int  bad   = 0;

  logic [31:0] rf [32];

  always #5 clk = ~clk;

  scr1_pipe_mprf_wb dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .dec_rs1_addr_i      (dec_rs1),
    .dec_rs2_addr_i      (dec_rs2),
    .dec_rd_addr_i       (dec_rd),
    .dec_stall_o         (dec_stall),
    .exu_rs1_data_o      (exu_rs1),
    .exu_rs2_data_o      (exu_rs2),
    .alu_wb_vd_i         (alu_vd),
    .alu_wb_rd_i         (alu_rd),
    .alu_wb_data_i       (alu_data),
    .lsu_issue_vd_i      (iss_vd),
    .lsu_issue_rd_i      (iss_rd),
    .lsu_issue_rdy_o     (iss_rdy),
    .lsu_rsp_vd_i        (rsp_vd),
    .lsu_rsp_data_i      (rsp_data),
    .lsu_rsp_err_i       (rsp_err),
    .lsu_rsp_rdy_o       (rsp_rdy),
    .exu2mprf_rs1_addr_o (rd_a1),
    .exu2mprf_rs2_addr_o (rd_a2),
    .mprf2exu_rs1_data_i (rf_d1),
    .mprf2exu_rs2_data_i (rf_d2),
    .exu2mprf_w_req_o    (w_req),
    .exu2mprf_rd_addr_o  (w_addr),
    .exu2mprf_rd_data_o  (w_data)
  );

  // Register-file model behind the read/write ports
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (w_req && w_addr != 5'd0) begin
      rf[w_addr] <= w_data;
    end
  end
  assign rf_d1 = (rd_a1 == 5'd0) ? 32'd0 : rf[rd_a1];
  assign rf_d2 = (rd_a2 == 5'd0) ? 32'd0 : rf[rd_a2];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Compare any write-port activity against the oldest expected write
  task automatic sb_check();
    wr_t e;
    if (w_req === 1'b1) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $error("FAIL sb_unexpected: observed=%h/%h expected=none", w_addr, w_data);
      end else begin
        e = exp_q.pop_front();
        assert ({w_addr, w_data} === {e.rd, e.data}) else begin
          bad++;
          $error("FAIL sb_write: observed=%h/%h expected=%h/%h", w_addr, w_data, e.rd, e.data);
        end
      end
    end
  endtask

  task automatic idle();
    dec_rs1 = '0; dec_rs2 = '0; dec_rd = '0;
    alu_vd = 1'b0; alu_rd = '0; alu_data = '0;
    iss_vd = 1'b0; iss_rd = '0;
    rsp_vd = 1'b0; rsp_data = '0; rsp_err = 1'b0;
  endtask

  task automatic next();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic at_neg();
    @(negedge clk);
    sb_check();
  endtask

  function automatic wr_t mk(input logic [4:0] rd, input logic [31:0] d);
    wr_t w;
    w.rd = rd;
    w.data = d;
    return w;
  endfunction

  initial begin
    // ---------------- reset state
    rst_n = 1'b0;
    idle();
    at_neg();
    chk("rst_stall", dec_stall, 1'b0);
    chk("rst_iss_rdy", iss_rdy, 1'b1);
    chk("rst_rsp_rdy", rsp_rdy, 1'b0);
    chk("rst_wreq", w_req, 1'b0);
    next();
    rst_n = 1'b1;
    at_neg();
    chk("idle_wreq", w_req, 1'b0);
    chk("idle_waddr", w_addr, 5'd0);

    // ---------------- ALU write with same-cycle bypass
    next();
    alu_vd = 1'b1; alu_rd = 5'd5; alu_data = 32'h1234_5678; dec_rs1 = 5'd5;
    exp_q.push_back(mk(5'd5, 32'h1234_5678));
    at_neg();
    chk("alu_wreq", w_req, 1'b1);
    chk("alu_bypass_rs1", exu_rs1, 32'h1234_5678);
    chk("alu_rs2_x0", exu_rs2, 32'd0);
    next();
    dec_rs1 = 5'd5;
    at_neg();
    chk("alu_rf_read", exu_rs1, 32'h1234_5678);
    chk("alu_after_wreq", w_req, 1'b0);

    // ---------------- load rd=7, RAW stall, response 3 cycles later
    next();
    iss_vd = 1'b1; iss_rd = 5'd7; dec_rs2 = 5'd7;
    at_neg();
    chk("ld7_iss_rdy", iss_rdy, 1'b1);
    chk("ld7_stall_issue_cyc", dec_stall, 1'b0);
    for (int i = 0; i < 2; i++) begin
      next();
      dec_rs2 = 5'd7;
      at_neg();
      chk("ld7_stall_wait", dec_stall, 1'b1);
    end
    next();
    dec_rs2 = 5'd7; rsp_vd = 1'b1; rsp_data = 32'hDEAD_BEEF;
    exp_q.push_back(mk(5'd7, 32'hDEAD_BEEF));
    at_neg();
    chk("ld7_rsp_rdy", rsp_rdy, 1'b1);
    chk("ld7_wreq", w_req, 1'b1);
    chk("ld7_bypass_rs2", exu_rs2, 32'hDEAD_BEEF);
    chk("ld7_stall_drop", dec_stall, 1'b0);
    next();
    dec_rs2 = 5'd7;
    at_neg();
    chk("ld7_rf_read", exu_rs2, 32'hDEAD_BEEF);
    chk("ld7_rsp_rdy_after", rsp_rdy, 1'b0);

    // ---------------- hold register: loads rd=3, rd=6 vs ALU conflicts
    next();
    iss_vd = 1'b1; iss_rd = 5'd3;
    at_neg();
    next();
    iss_vd = 1'b1; iss_rd = 5'd6;
    at_neg();
    chk("b2b_iss_rdy_2nd", iss_rdy, 1'b1);
    next();
    rsp_vd = 1'b1; rsp_data = 32'hCAFE_0003;
    alu_vd = 1'b1; alu_rd = 5'd4; alu_data = 32'h4444_0004;
    dec_rs1 = 5'd3;
    exp_q.push_back(mk(5'd4, 32'h4444_0004));
    at_neg();
    chk("hold_iss_rdy_full", iss_rdy, 1'b0);
    chk("hold_rsp_rdy", rsp_rdy, 1'b1);
    chk("hold_waddr_alu", w_addr, 5'd4);
    chk("hold_stall_rs1", dec_stall, 1'b1);
    next();
    alu_vd = 1'b1; alu_rd = 5'd8; alu_data = 32'h8888_0008;
    dec_rs1 = 5'd3;
    exp_q.push_back(mk(5'd8, 32'h8888_0008));
    exp_q.push_back(mk(5'd3, 32'hCAFE_0003));
    at_neg();
    chk("hold_full_rsp_rdy", rsp_rdy, 1'b0);
    chk("hold_iss_rdy_freed", iss_rdy, 1'b1);
    chk("hold_stall_still", dec_stall, 1'b1);
    next();
    dec_rs1 = 5'd3;
    at_neg();
    chk("hold_drain_wreq", w_req, 1'b1);
    chk("hold_bypass_rs1", exu_rs1, 32'hCAFE_0003);
    chk("hold_stall_drop", dec_stall, 1'b0);
    chk("hold_drain_rsp_rdy", rsp_rdy, 1'b0);
    next();
    rsp_vd = 1'b1; rsp_data = 32'h6666_0006;
    exp_q.push_back(mk(5'd6, 32'h6666_0006));
    at_neg();
    chk("ld6_rsp_rdy", rsp_rdy, 1'b1);
    chk("ld6_wreq", w_req, 1'b1);

    // ---------------- full FIFO with simultaneous issue and response
    next();
    iss_vd = 1'b1; iss_rd = 5'd10;
    at_neg();
    next();
    iss_vd = 1'b1; iss_rd = 5'd11;
    at_neg();
    next();
    iss_vd = 1'b1; iss_rd = 5'd12;
    rsp_vd = 1'b1; rsp_data = 32'hAAAA_000A;
    exp_q.push_back(mk(5'd10, 32'hAAAA_000A));
    at_neg();
    chk("full_pop_iss_rdy", iss_rdy, 1'b0);
    next();
    iss_vd = 1'b1; iss_rd = 5'd12;
    rsp_vd = 1'b1; rsp_data = 32'hBBBB_000B;
    exp_q.push_back(mk(5'd11, 32'hBBBB_000B));
    at_neg();
    chk("pushpop_iss_rdy", iss_rdy, 1'b1);
    chk("pushpop_wreq", w_req, 1'b1);
    next();
    rsp_vd = 1'b1; rsp_data = 32'hCCCC_000C; dec_rs1 = 5'd12;
    exp_q.push_back(mk(5'd12, 32'hCCCC_000C));
    at_neg();
    chk("ld12_wreq", w_req, 1'b1);
    chk("ld12_bypass", exu_rs1, 32'hCCCC_000C);
    chk("ld12_stall", dec_stall, 1'b0);
    next();
    at_neg();
    chk("drained_rsp_rdy", rsp_rdy, 1'b0);

    // ---------------- faulted load rd=9
    next();
    iss_vd = 1'b1; iss_rd = 5'd9;
    at_neg();
    next();
    dec_rd = 5'd9;
    at_neg();
    chk("ld9_waw_stall", dec_stall, 1'b1);
    next();
    dec_rs1 = 5'd9;
    at_neg();
    chk("ld9_raw_stall", dec_stall, 1'b1);
    next();
    dec_rs1 = 5'd9; rsp_vd = 1'b1; rsp_err = 1'b1; rsp_data = 32'h9999_9999;
    at_neg();
    chk("ld9_err_wreq", w_req, 1'b0);
    chk("ld9_err_stall", dec_stall, 1'b0);
    chk("ld9_err_rs1", exu_rs1, 32'd0);
    next();
    dec_rs1 = 5'd9;
    at_neg();
    chk("ld9_after_stall", dec_stall, 1'b0);

    // ---------------- ALU to x0 does not block a direct load write
    next();
    iss_vd = 1'b1; iss_rd = 5'd13;
    at_neg();
    next();
    rsp_vd = 1'b1; rsp_data = 32'hDDDD_000D;
    alu_vd = 1'b1; alu_rd = 5'd0; alu_data = 32'hFFFF_FFFF;
    dec_rs2 = 5'd13;
    exp_q.push_back(mk(5'd13, 32'hDDDD_000D));
    at_neg();
    chk("x0alu_wreq", w_req, 1'b1);
    chk("x0alu_bypass", exu_rs2, 32'hDDDD_000D);

    // ---------------- reset with hold FULL and loads outstanding
    next();
    iss_vd = 1'b1; iss_rd = 5'd14;
    at_neg();
    next();
    iss_vd = 1'b1; iss_rd = 5'd15;
    at_neg();
    next();
    rsp_vd = 1'b1; rsp_data = 32'hEEEE_000E;
    alu_vd = 1'b1; alu_rd = 5'd1; alu_data = 32'h1111_0001;
    exp_q.push_back(mk(5'd1, 32'h1111_0001));
    at_neg();
    next();
    alu_vd = 1'b1; alu_rd = 5'd2; alu_data = 32'h2222_0002;
    dec_rs1 = 5'd15;
    exp_q.push_back(mk(5'd2, 32'h2222_0002));
    at_neg();
    chk("prerst_rsp_rdy", rsp_rdy, 1'b0);
    chk("prerst_iss_rdy", iss_rdy, 1'b1);
    chk("prerst_stall", dec_stall, 1'b1);
    #1;
    idle();
    dec_rs1 = 5'd15; dec_rs2 = 5'd14;
    rst_n = 1'b0;
    #1;
    chk("midrst_stall", dec_stall, 1'b0);
    chk("midrst_iss_rdy", iss_rdy, 1'b1);
    chk("midrst_rsp_rdy", rsp_rdy, 1'b0);
    chk("midrst_wreq", w_req, 1'b0);
    next();
    rst_n = 1'b1;
    dec_rs1 = 5'd15; dec_rs2 = 5'd14;
    at_neg();
    chk("postrst_wreq", w_req, 1'b0);
    chk("postrst_stall", dec_stall, 1'b0);
    chk("postrst_rsp_rdy", rsp_rdy, 1'b0);

    // ---------------- every expected write must have been seen
    chk("sb_leftover", exp_q.size(), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Bound on total run time
  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1);
  end

endmodule : tb_scr1_pipe_mprf_wb
`default_nettype wire
